// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-block slave bus
// between NUM_REQ masters, one access outstanding at a time.
module reg_bus_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int NUM_REQ    = 2
) (
  input  logic                          reg_clk,
  input  logic                          reg_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0]          req_we,
  input  logic [NUM_REQ*32-1:0]         req_wdat,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [31:0]                   rsp_rdat,
  output logic                          reg_wr,
  output logic                          reg_rd,
  output logic [3:0]                    reg_we,
  output logic [ADDR_WIDTH-1:0]         reg_addr,
  output logic [31:0]                   reg_wdat,
  input  logic [31:0]                   reg_rdat,
  output logic                          busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDCAP,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      ptr_nxt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [IW-1:0]      lat_idx;
  logic               lat_write;
  logic [NUM_REQ-1:0] one_hot;

  assign one_hot = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // Pick the first requester at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  // Pointer moves to the master after the one just granted.
  always_comb begin
    ptr_nxt = gnt_idx + IW'(1);
    if (gnt_idx == IW'(NUM_REQ - 1)) ptr_nxt = '0;
  end

  // State register.
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state plus handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (gnt_any) begin
          state_nxt = ISSUE;
          if (!reg_rst) req_ready = one_hot << gnt_idx;
        end
      end
      ISSUE: state_nxt = lat_write ? RESP : RDCAP;
      RDCAP: state_nxt = RESP;
      RESP: begin
        state_nxt = IDLE;
        rsp_valid = one_hot << lat_idx;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accept a request: the bus registers double as the latch
  // for address/enables/data, since they are only live in ISSUE.
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      rr_ptr    <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_we    <= '0;
      reg_addr  <= '0;
      reg_wdat  <= '0;
      rsp_rdat  <= '0;
    end else begin
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      reg_we   <= '0;
      reg_addr <= '0;
      reg_wdat <= '0;
      if (state == IDLE && gnt_any) begin
        rr_ptr    <= ptr_nxt;
        lat_idx   <= gnt_idx;
        lat_write <= req_write[gnt_idx];
        reg_wr    <= req_write[gnt_idx];
        reg_rd    <= !req_write[gnt_idx];
        reg_addr  <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        if (req_write[gnt_idx]) begin
          reg_we   <= req_we[gnt_idx*4 +: 4];
          reg_wdat <= req_wdat[gnt_idx*32 +: 32];
        end
      end
      if (state == RDCAP) rsp_rdat <= reg_rdat;
    end
  end

endmodule
